s386_resp_misr: RTL
===================

Name: s386_resp_misr

Overview:
- Response compactor that sits directly downstream of the s386 benchmark core.
- Consumes the seven per-cycle outputs (v13_D_6..v13_D_12) and folds them into a 16-bit multiple-input signature register (MISR) over a programmed number of vectors.
- Presents the final signature and a pass/fail compare against a golden value, so on-FPGA runs of the benchmark can be checked without streaming every output off-chip.

Parameters:
- DIN_WIDTH, 7, width of the compacted response bus (the s386 output count)
- SIG_WIDTH, 16, MISR/signature width; must be >= DIN_WIDTH
- POLY, 16'h1021, feedback polynomial XOR mask applied when the MISR MSB is 1
- SEED, 16'h0000, MISR value loaded on start
- NUM_VECTORS, 256, number of valid input vectors compacted per run; range 1..65535
- GOLDEN, 16'h0000, expected signature for the pass output

Ports:
- clk, input, 1, single clock; all state updates on rising edge
- rst_n, input, 1, asynchronous active-low reset
- start, input, 1, one-cycle request to begin a run
- din, input, DIN_WIDTH, response bit j = v13_D_(6+j), j = 0..6
- din_valid, input, 1, din holds a vector to compact this cycle
- busy, output, 1, high while in RUN
- done, output, 1, high while in DONE (signature final)
- sig, output, SIG_WIDTH, current MISR contents
- pass, output, 1, valid only when done=1: sig == GOLDEN
- vec_cnt, output, 16, number of vectors compacted so far in this run

Behaviour:
- Reset is asynchronous and active-low. While rst_n=0:
  - state=IDLE
  - sig=SEED, vec_cnt=0, busy=0, done=0, pass=0
- Reset asserted mid-run aborts immediately; no partial signature is retained.
- MISR update, applied only in RUN when din_valid=1:
  - sig_next = ({sig[SIG_WIDTH-2:0],1'b0} ^ (sig[SIG_WIDTH-1] ? POLY : 0)) ^ zero_extend(din)
  - din XORs into bits [DIN_WIDTH-1:0].
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start=1 -> load sig=SEED, vec_cnt=0, go to RUN next cycle.
  - din_valid in IDLE is ignored.
- RUN:
  - busy=1.
  - Each cycle with din_valid=1: apply the MISR update and vec_cnt+=1.
  - When the vector being accepted is number NUM_VECTORS (vec_cnt==NUM_VECTORS-1 before the increment), go to DONE next cycle. sig then holds the final signature and vec_cnt=NUM_VECTORS.
  - din_valid=0 holds all state (stall); no timeout.
  - start in RUN is ignored; it does not restart the run.
- DONE:
  - done=1, busy=0; sig and vec_cnt are frozen.
  - pass = (sig==GOLDEN), registered or combinational from frozen sig, and stable throughout DONE.
  - din_valid is ignored.
  - start=1 -> reload SEED, vec_cnt=0, go to RUN next cycle (done drops that same edge).
- Latency and handshake:
  - The first vector can be accepted in the cycle after start is sampled.
  - done asserts in the cycle after the last vector is accepted.
  - din has no backpressure; the core free-runs and din_valid qualifies cycles, e.g. masking the DFF pipeline fill after core reset.
- Boundary conditions:
  - NUM_VECTORS=1: a single valid vector completes the run.
  - vec_cnt never wraps, since the run ends at NUM_VECTORS.
  - start and din_valid both high in IDLE/DONE: only start acts; that din is not compacted.
  - done and busy are never high together.

Test Plan:
- Reset: rst_n=0 asynchronously mid-RUN after 10 vectors -> immediately busy=0, done=0, sig=16'h0000, vec_cnt=0; after release, FSM idles until start.
- Single vector: NUM_VECTORS=1, SEED=0, start, then din=7'h01 valid one cycle -> next cycle done=1, sig=16'h0001, vec_cnt=1, pass=0 (GOLDEN=0).
- Shift and stall: NUM_VECTORS=2, SEED=0; din=7'h01 valid, 3 cycles din_valid=0, din=7'h00 valid -> sig=16'h0002 at done, vec_cnt=2; sig stays 16'h0001 during the stall.
- Feedback: NUM_VECTORS=1, SEED=16'h8000, din=7'h00 valid -> sig=16'h1021. Repeat with din=7'h7F -> sig=16'h105E.
- Pass check: NUM_VECTORS=1, SEED=0, GOLDEN=16'h0040, din=7'h40 -> done=1, pass=1. Holding done for 5 cycles with din_valid toggling leaves sig unchanged.
- Restart/ignore: start pulsed during RUN -> no effect, vec_cnt continues. start in DONE -> next cycle busy=1, done=0, sig=SEED, vec_cnt=0. Full run with NUM_VECTORS=256 and all-zero din, SEED=0 -> sig=0, vec_cnt=256.

Source files
------------

// File: rtl/s386_resp_misr.sv
// Response compactor for the s386 core: folds qualified 7-bit output vectors
// into a 16-bit MISR over a fixed run length and compares against a golden signature.
module s386_resp_misr #(
    parameter int unsigned                DIN_WIDTH   = 7,
    parameter int unsigned                SIG_WIDTH   = 16,
    parameter logic [SIG_WIDTH-1:0]       POLY        = 16'h1021,
    parameter logic [SIG_WIDTH-1:0]       SEED        = 16'h0000,
    parameter int unsigned                NUM_VECTORS = 256,
    parameter logic [SIG_WIDTH-1:0]       GOLDEN      = 16'h0000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [DIN_WIDTH-1:0] din,
    input  logic                 din_valid,
    output logic                 busy,
    output logic                 done,
    output logic [SIG_WIDTH-1:0] sig,
    output logic                 pass,
    output logic [15:0]          vec_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [15:0] LAST_IDX = 16'(NUM_VECTORS - 1);

    state_t               state_q, state_d;
    logic [SIG_WIDTH-1:0] sig_q, sig_d;
    logic [15:0]          cnt_q, cnt_d;
    logic [SIG_WIDTH-1:0] misr_next;

    // Shift left, apply polynomial feedback on MSB, then fold din into the low bits
    always_comb begin
        misr_next = {sig_q[SIG_WIDTH-2:0], 1'b0};
        if (sig_q[SIG_WIDTH-1]) begin
            misr_next = misr_next ^ POLY;
        end
        misr_next = misr_next ^ SIG_WIDTH'(din);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sig_q   <= SEED;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sig_q   <= sig_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sig_d   = sig_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    sig_d   = SEED;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (din_valid) begin
                    sig_d = misr_next;
                    cnt_d = cnt_q + 16'd1;
                    if (cnt_q == LAST_IDX) begin
                        state_d = DONE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy    = (state_q == RUN);
    assign done    = (state_q == DONE);
    assign sig     = sig_q;
    assign vec_cnt = cnt_q;
    assign pass    = (state_q == DONE) && (sig_q == GOLDEN);

endmodule
